mem_arb64: RTL and testbench
============================

Name: mem_arb64

Overview:
- Two-requester arbiter for the shared 64-bit Avalon memory master port.
- Port A is typically the processor/memory-bus side; port B is the console/host interface register block.
- Serialises whole read/write transactions, alternating ownership round-robin when both ports request.
- A watchdog terminates transfers the memory slave never accepts.

Parameters:
TIMEOUT, 1023, cycles m_waitrequest may stay high before abort; 0 disables watchdog.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
a_address  in  32  requester A word address
a_read  in  1  requester A read request
a_write  in  1  requester A write request
a_writedata  in  64  requester A write data
a_readdata  out  64  requester A read data, registered
a_waitrequest  out  1  requester A stall
b_address, b_read, b_write, b_writedata, b_readdata, b_waitrequest  same as A, for requester B
m_address  out  32  master address, registered
m_read  out  1  master read strobe, registered
m_write  out  1  master write strobe, registered
m_writedata  out  64  master write data, registered
m_readdata  in  64  slave read data
m_waitrequest  in  1  slave stall
owner  out  1  0=A, 1=B; valid while busy
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async, reset low) values:
  - State IDLE.
  - m_read=m_write=0; m_address=0; m_writedata=0.
  - a_readdata=b_readdata=0; owner=0; timeout_err=0; last=1, so A wins the first tie; watchdog counter=0.
- A port requests when its read|write is high. Write has precedence if both are high: command = write.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay.
  - Single request: grant that port.
  - Both request: grant ~last.
  - On grant, latch the winner's address, writedata and command into m_* and set owner and last=winner. The m_read or m_write strobe is high the next cycle. Go to BUSY.
- BUSY:
  - On the cycle m_read|m_write is high and m_waitrequest=0, the slave accepts. Next edge: clear the strobe; on a read, load m_readdata into the owner's readdata register. Go to DONE.
  - Otherwise increment the watchdog.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: clear the strobe, set timeout_err, load 0 into the owner's readdata on a read, go to DONE.
- DONE: lasts one cycle; the owner's waitrequest is low in it. Go to IDLE; the watchdog clears.
- x_waitrequest = (x_read|x_write) & ~(state==DONE & owner==x). Combinational: a request sees waitrequest high in the same cycle it is raised.
- Latency: an uncontested request at cycle 0 gives m strobe at cycle 1. Slave accept at cycle k gives requester completion (waitrequest low, readdata valid) at cycle k+1. IDLE is at k+2, and the next grant comes no earlier than k+2.
- Fairness:
  - A port that completes cannot win a tie on the next grant.
  - Back-to-back requests from both ports alternate A, B, A, B.
  - A single active port may issue back-to-back transactions.
- Requests and data are sampled only at grant. Changes on the owner's inputs while BUSY are ignored.
- A request withdrawn mid-transaction (protocol violation) does not abort it. The master transfer completes normally and the DONE cycle is harmless.
- x_readdata holds its value until that port's next read completes. A writes never alter x_readdata.
- timeout_err is sticky. err_clr clears it. If err_clr coincides with a new timeout, the set wins.
- Reset asserted mid-transaction drops strobes immediately. Any in-flight slave transaction is abandoned.
- Watchdog width is clog2(TIMEOUT+1). The counter saturates and never wraps.

Test Plan:
- A read 0x00000010, slave waitrequest 2 cycles, m_readdata=0x0123456789ABCDEF -> m_read high cycles 1-3 with m_address=0x10; a_waitrequest low cycle 4 with a_readdata=0x0123456789ABCDEF; b unaffected.
- A and B write simultaneously (A addr 0x20 data 0xAA.., B addr 0x30 data 0xBB..), slave 0-wait -> A transfer first, then B; owner 0 then 1; m_write never high for both addresses at once.
- Both ports issue continuous reads for 6 transactions -> grant order A,B,A,B,A,B; each port's readdata holds its own transfer's data.
- TIMEOUT=8, B read, m_waitrequest stuck high -> m_read drops after 8 wait cycles; timeout_err=1; b_readdata=0; b_waitrequest low for one cycle; err_clr pulse -> timeout_err=0.
- Reset pulsed low while BUSY with m_write high -> m_write=0 and state IDLE immediately. After release, a pending A request is granted normally with owner=0.
- A asserts read and write together, addr 0x40 -> m_write issued, m_read never high; a_readdata unchanged.

Source files
------------

// File: rtl/mem_arb64.sv
// Round-robin arbiter that shares one 64-bit Avalon master port between requesters A and B.
// A watchdog aborts transfers that the slave never accepts.
module mem_arb64 #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_address,
    input  logic        a_read,
    input  logic        a_write,
    input  logic [63:0] a_writedata,
    output logic [63:0] a_readdata,
    output logic        a_waitrequest,
    input  logic [31:0] b_address,
    input  logic        b_read,
    input  logic        b_write,
    input  logic [63:0] b_writedata,
    output logic [63:0] b_readdata,
    output logic        b_waitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_writedata,
    input  logic [63:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        owner,
    output logic        timeout_err,
    input  logic        err_clr
);

    // A zero-width counter is illegal, so a disabled watchdog still keeps one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_MAX   = '1;
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wd_cnt;
    logic [CW-1:0] wd_inc;
    logic          last;
    logic          a_req;
    logic          b_req;
    logic          grant_b;
    logic          accept;
    logic          expire;
    logic [31:0]   win_address;
    logic [63:0]   win_writedata;
    logic          win_read;
    logic          win_write;

    assign a_req = a_read | a_write;
    assign b_req = b_read | b_write;

    // The completion cycle is the only one in which the owner's stall is released.
    assign a_waitrequest = a_req & ~(state == DONE && owner == 1'b0);
    assign b_waitrequest = b_req & ~(state == DONE && owner == 1'b1);

    always_comb begin
        grant_b       = b_req & (~a_req | ~last);
        win_address   = grant_b ? b_address : a_address;
        win_writedata = grant_b ? b_writedata : a_writedata;
        win_read      = grant_b ? b_read : a_read;
        win_write     = grant_b ? b_write : a_write;
        wd_inc        = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CW'(1);
        accept        = (m_read | m_write) & ~m_waitrequest;
        expire        = (TIMEOUT != 0) && (wd_inc == WD_LIMIT) && !accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (a_req | b_req) state_next = BUSY;
            BUSY:    if (accept | expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Master-side command registers, ownership and the watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_address   <= '0;
            m_writedata <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            owner       <= 1'b0;
            last        <= 1'b1;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        m_address   <= win_address;
                        m_writedata <= win_writedata;
                        m_write     <= win_write;
                        m_read      <= win_read & ~win_write;
                        owner       <= grant_b;
                        last        <= grant_b;
                        wd_cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (accept || expire) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end
                    if (!accept) begin
                        wd_cnt <= wd_inc;
                    end
                end
                DONE: begin
                    wd_cnt <= '0;
                end
                default: begin
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                end
            endcase
        end
    end

    // An aborted read returns zero so the owner never sees stale slave data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_readdata <= '0;
            b_readdata <= '0;
        end else if (state == BUSY && m_read && (accept || expire)) begin
            if (owner) begin
                b_readdata <= accept ? m_readdata : '0;
            end else begin
                a_readdata <= accept ? m_readdata : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (state == BUSY && expire) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arb64.sv
// Self-checking bench for mem_arb64: directed scenarios plus randomized traffic, checked
// against a transaction-level model of requesters, round-robin arbitration and a slave.
module tb_mem_arb64;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a_address = '0;
    logic        a_read = 1'b0;
    logic        a_write = 1'b0;
    logic [63:0] a_writedata = '0;
    logic [63:0] a_readdata;
    logic        a_waitrequest;
    logic [31:0] b_address = '0;
    logic        b_read = 1'b0;
    logic        b_write = 1'b0;
    logic [63:0] b_writedata = '0;
    logic [63:0] b_readdata;
    logic        b_waitrequest;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [63:0] m_writedata;
    logic [63:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;
    logic        owner;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    mem_arb64 #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_readdata(a_readdata), .a_waitrequest(a_waitrequest),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_readdata(b_readdata), .b_waitrequest(b_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .owner(owner), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        int          gap;
    } txn_t;

    txn_t qa[$];
    txn_t qb[$];
    int   grants[$];

    int vectors = 0;
    int miscompares = 0;

    // Requester model: the transaction each port currently presents.
    bit          act[2];
    bit          prd[2];
    bit          pwr[2];
    logic [31:0] padr[2];
    logic [63:0] pdat[2];
    logic [63:0] exp_rd[2];
    bit          retire[2];
    int          gap_left[2];
    bit          gap_loaded[2];

    // Arbiter and slave model at the transaction level.
    bit          arb_free;
    bit          in_done;
    bit          last_w;
    bit          xfer_w;
    bit          exp_err;
    bit          stuck;
    bit          drv_wait;
    bit          use_force_rd;
    int          wait_left;
    int          wd;
    int          force_wait;
    logic [63:0] rdval;
    logic [63:0] force_rd;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [63:0] data, input int gap);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.data = data; t.gap = gap;
        if (p == 0) qa.push_back(t);
        else        qb.push_back(t);
    endtask

    function automatic bit req(input int p);
        return act[p] & (prd[p] | pwr[p]);
    endfunction

    task automatic model_reset();
        arb_free = 1'b1; in_done = 1'b0; last_w = 1'b1; exp_err = 1'b0;
        wd = 0; wait_left = 0; xfer_w = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic drive_inputs();
        a_read = act[0] & prd[0];
        a_write = act[0] & pwr[0];
        a_address = act[0] ? padr[0] : $urandom;
        a_writedata = act[0] ? pdat[0] : {$urandom, $urandom};
        b_read = act[1] & prd[1];
        b_write = act[1] & pwr[1];
        b_address = act[1] ? padr[1] : $urandom;
        b_writedata = act[1] ? pdat[1] : {$urandom, $urandom};
        if (!arb_free && !in_done) drv_wait = stuck || (wait_left > 0);
        else drv_wait = 1'($urandom_range(0, 1));
        m_waitrequest = drv_wait;
        m_readdata = drv_wait ? {$urandom, $urandom} : rdval;
    endtask

    task automatic update_port(input int p);
        txn_t t;
        if (retire[p] && !in_done) begin
            act[p] = 1'b0;
            retire[p] = 1'b0;
        end
        if (!act[p] && ((p == 0) ? qa.size() : qb.size()) > 0) begin
            if (p == 0) t = qa[0];
            else        t = qb[0];
            if (!gap_loaded[p]) begin
                gap_left[p] = t.gap;
                gap_loaded[p] = 1'b1;
            end
            if (gap_left[p] > 0) begin
                gap_left[p]--;
            end else begin
                if (p == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
                act[p] = 1'b1; prd[p] = t.rd; pwr[p] = t.wr;
                padr[p] = t.addr; pdat[p] = t.data;
                gap_loaded[p] = 1'b0;
            end
        end
    endtask

    task automatic finish_xfer(input logic [63:0] data);
        in_done = 1'b1;
        retire[xfer_w] = 1'b1;
        checkOutput("done_m_read", m_read, 0);
        checkOutput("done_m_write", m_write, 0);
        if (prd[xfer_w] && !pwr[xfer_w]) exp_rd[xfer_w] = data;
    endtask

    task automatic run_cycle();
        bit pa, pb, clr_prev, dw, set_now;
        drive_inputs();
        pa = req(0); pb = req(1); clr_prev = err_clr; dw = drv_wait;
        @(posedge clk); #1;
        set_now = 1'b0;
        if (in_done) begin
            in_done = 1'b0;
            arb_free = 1'b1;
        end else if (!arb_free) begin
            if (!dw) begin
                finish_xfer(rdval);
            end else begin
                if (wait_left > 0) wait_left--;
                wd++;
                if (wd == TO) begin
                    finish_xfer(64'h0);
                    set_now = 1'b1;
                end else begin
                    checkOutput("hold_m_read", m_read, prd[xfer_w] & ~pwr[xfer_w]);
                    checkOutput("hold_m_write", m_write, pwr[xfer_w]);
                    checkOutput("hold_m_address", m_address, padr[xfer_w]);
                end
            end
        end else if (pa || pb) begin
            xfer_w = (pa && pb) ? ~last_w : pb;
            last_w = xfer_w;
            arb_free = 1'b0;
            wd = 0;
            wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            rdval = use_force_rd ? force_rd : {$urandom, $urandom};
            grants.push_back(int'(xfer_w));
            checkOutput("grant_owner", owner, xfer_w);
            checkOutput("grant_m_address", m_address, padr[xfer_w]);
            checkOutput("grant_m_writedata", m_writedata, pdat[xfer_w]);
            checkOutput("grant_m_write", m_write, pwr[xfer_w]);
            checkOutput("grant_m_read", m_read, prd[xfer_w] & ~pwr[xfer_w]);
        end else begin
            checkOutput("idle_strobe", m_read | m_write, 0);
        end
        if (set_now) exp_err = 1'b1;
        else if (clr_prev) exp_err = 1'b0;
        checkOutput("timeout_err", timeout_err, exp_err);
        checkOutput("a_readdata", a_readdata, exp_rd[0]);
        checkOutput("b_readdata", b_readdata, exp_rd[1]);
        checkOutput("a_waitrequest", a_waitrequest, req(0) && !(in_done && xfer_w == 1'b0));
        checkOutput("b_waitrequest", b_waitrequest, req(1) && !(in_done && xfer_w == 1'b1));
        update_port(0);
        update_port(1);
    endtask

    task automatic run_until_quiet(input int budget);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || act[0] || act[1] || !arb_free || in_done)
               && n < budget) begin
            run_cycle();
            n++;
        end
        checkOutput("quiesce_budget", n < budget, 1);
    endtask

    initial begin
        int kind;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; prd[p] = 0; pwr[p] = 0; padr[p] = '0; pdat[p] = '0;
            retire[p] = 0; gap_left[p] = 0; gap_loaded[p] = 0;
        end
        stuck = 0; force_wait = -1; use_force_rd = 0; force_rd = '0; rdval = '0;
        model_reset();

        @(posedge clk); #1;
        checkOutput("rst_m_read", m_read, 0);
        checkOutput("rst_m_write", m_write, 0);
        checkOutput("rst_m_address", m_address, 0);
        checkOutput("rst_m_writedata", m_writedata, 0);
        checkOutput("rst_a_readdata", a_readdata, 0);
        checkOutput("rst_b_readdata", b_readdata, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;

        $display("[TB] simultaneous writes, zero-wait slave");
        force_wait = 0;
        applyStimulus(0, 0, 1, 32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 0);
        applyStimulus(1, 0, 1, 32'h30, 64'hBBBB_BBBB_BBBB_BBBB, 0);
        grants.delete();
        run_until_quiet(50);
        force_wait = -1;
        checkOutput("wr_grant_count", grants.size(), 2);
        for (int i = 0; i < grants.size(); i++) checkOutput("wr_grant_order", grants[i], i % 2);

        $display("[TB] continuous reads from both ports");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'h100 + i, {$urandom, $urandom}, 0);
            applyStimulus(1, 1, 0, 32'h200 + i, {$urandom, $urandom}, 0);
        end
        grants.delete();
        run_until_quiet(200);
        checkOutput("rd_grant_count", grants.size(), 6);
        for (int i = 0; i < grants.size(); i++) checkOutput("rd_grant_order", grants[i], i % 2);

        $display("[TB] single read with two slave wait states");
        force_wait = 2; use_force_rd = 1; force_rd = 64'h0123_4567_89AB_CDEF;
        applyStimulus(0, 1, 0, 32'h10, 64'h0, 0);
        run_until_quiet(50);
        force_wait = -1; use_force_rd = 0;
        checkOutput("a_read_data", a_readdata, 64'h0123_4567_89AB_CDEF);

        $display("[TB] watchdog abort on stuck slave");
        stuck = 1;
        applyStimulus(1, 1, 0, 32'h60, 64'h0, 0);
        run_until_quiet(50);
        stuck = 0;
        checkOutput("tmo_flag", timeout_err, 1);
        checkOutput("tmo_b_readdata", b_readdata, 0);
        err_clr = 1'b1;
        run_cycle();
        err_clr = 1'b0;
        run_cycle();

        $display("[TB] watchdog abort while err_clr held");
        stuck = 1; err_clr = 1'b1;
        applyStimulus(0, 1, 0, 32'h70, 64'h0, 0);
        run_until_quiet(50);
        stuck = 0; err_clr = 1'b0;
        run_cycle();

        $display("[TB] reset while a write is stalled");
        applyStimulus(1, 1, 0, 32'h80, 64'h0, 0);
        run_until_quiet(50);
        stuck = 1;
        applyStimulus(0, 0, 1, 32'h50, {$urandom, $urandom}, 0);
        for (int i = 0; i < 4; i++) run_cycle();
        reset = 1'b0;
        #1;
        checkOutput("midrst_m_write", m_write, 0);
        checkOutput("midrst_m_read", m_read, 0);
        checkOutput("midrst_owner", owner, 0);
        checkOutput("midrst_b_readdata", b_readdata, 0);
        checkOutput("midrst_a_wait", a_waitrequest, 1);
        model_reset();
        stuck = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_until_quiet(50);

        $display("[TB] read and write together");
        applyStimulus(1, 1, 0, 32'h90, 64'h0, 0);
        applyStimulus(0, 1, 0, 32'h91, 64'h0, 0);
        run_until_quiet(50);
        applyStimulus(0, 1, 1, 32'h40, 64'h4040_4040_4040_4040, 0);
        run_until_quiet(50);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30; i++) begin
            for (int p = 0; p < 2; p++) begin
                kind = $urandom_range(0, 2);
                applyStimulus(p, kind != 1, kind != 0, $urandom, {$urandom, $urandom},
                              $urandom_range(0, 3));
            end
        end
        run_until_quiet(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
